// File: rtl/gcd_pkg.sv
// ============================================================================
// gcd_pkg : shared encodings for the subtractive GCD controller
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package gcd_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_CALC   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic SEL_A       = 1'b0;
    localparam logic SEL_B       = 1'b1;
    localparam logic SEL_IN_DATA = 1'b0;
    localparam logic SEL_IN_SUB  = 1'b1;

    localparam int DEFAULT_MAX_ITER = 16;

endpackage

`default_nettype wire

// File: rtl/gcd_iter_counter.sv
// ============================================================================
// gcd_iter_counter : clear/enable subtract-cycle counter with terminal flag
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module gcd_iter_counter #(
    parameter int CNT_W    = 5,
    parameter int MAX_ITER = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_max = (count == CNT_W'(MAX_ITER));

endmodule

`default_nettype wire

// File: rtl/gcd_controller.sv
// ============================================================================
// gcd_controller : control FSM for the 4-bit subtractive GCD datapath
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module gcd_controller
    import gcd_pkg::*;
#(
    parameter int CNT_W    = 5,
    parameter int MAX_ITER = DEFAULT_MAX_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       data_in,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    output logic             in_ready,
    output logic             ldA,
    output logic             ldB,
    output logic             sel_in,
    output logic             sel1,
    output logic             sel2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iters
);

    logic [2:0] state;
    logic [2:0] state_next;
    logic       zero_seen;
    logic       cnt_clear;
    logic       cnt_enable;
    logic       cnt_at_max;
    logic       set_done;
    logic       set_err;
    logic       data_zero;
    logic       flag_eq;
    logic       flag_gt;
    logic       flag_lt;

    assign data_zero = (data_in == 4'd0);

    // A flag only counts when it is the sole flag raised; anything else is no decision.
    assign flag_eq = eq & ~lt & ~gt;
    assign flag_gt = gt & ~lt & ~eq;
    assign flag_lt = lt & ~gt & ~eq;

    gcd_iter_counter #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (iters),
        .at_max (cnt_at_max)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        ldA        = 1'b0;
        ldB        = 1'b0;
        sel_in     = SEL_IN_DATA;
        sel1       = SEL_A;
        sel2       = SEL_A;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        set_done   = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD_A;
                    cnt_clear  = 1'b1;
                end
            end
            S_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ldA        = 1'b1;
                    state_next = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ldB = 1'b1;
                    if (zero_seen || data_zero) begin
                        state_next = S_FINISH;
                        set_err    = 1'b1;
                    end else begin
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flag_eq) begin
                    state_next = S_FINISH;
                    set_done   = 1'b1;
                end else if (cnt_at_max) begin
                    state_next = S_FINISH;
                    set_err    = 1'b1;
                end else begin
                    // Contradictory flags still count an iteration so timeout is reached.
                    cnt_enable = 1'b1;
                    if (flag_gt) begin
                        ldA    = 1'b1;
                        sel_in = SEL_IN_SUB;
                        sel1   = SEL_A;
                        sel2   = SEL_B;
                    end else if (flag_lt) begin
                        ldB    = 1'b1;
                        sel_in = SEL_IN_SUB;
                        sel1   = SEL_B;
                        sel2   = SEL_A;
                    end
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            err       <= 1'b0;
            zero_seen <= 1'b0;
        end else if (cnt_clear) begin
            done      <= 1'b0;
            err       <= 1'b0;
            zero_seen <= 1'b0;
        end else begin
            done <= done | set_done;
            err  <= err | set_err;
            if (in_ready && in_valid && data_zero) begin
                zero_seen <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gcd_controller.sv
// ============================================================================
// tb_gcd_controller : directed bench pairing the controller with a GCD datapath
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_gcd_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // Instance 1: default MAX_ITER
    logic       start = 1'b0, in_valid = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic       lt, gt, eq, in_ready, ldA, ldB, sel_in, sel1, sel2, busy, done, err;
    logic [4:0] iters;
    logic [3:0] a_reg, b_reg, bus, sub;

    // Instance 2: MAX_ITER = 4
    logic       start2 = 1'b0, in_valid2 = 1'b0;
    logic [3:0] data_in2 = 4'd0;
    logic       lt2, gt2, eq2, in_ready2, ldA2, ldB2, sel_in2, sel1_2, sel2_2, busy2, done2, err2;
    logic [4:0] iters2;
    logic [3:0] a_reg2, b_reg2, bus2, sub2;

    int n_checks = 0;
    int n_fail   = 0;
    int lda_cnt  = 0;
    int ldb_cnt  = 0;
    int both_cnt = 0;
    int sel_viol = 0;

    always #5 clk = ~clk;

    gcd_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .data_in(data_in),
        .lt(lt), .gt(gt), .eq(eq), .in_ready(in_ready), .ldA(ldA), .ldB(ldB),
        .sel_in(sel_in), .sel1(sel1), .sel2(sel2), .busy(busy), .done(done), .err(err),
        .iters(iters)
    );

    gcd_controller #(.CNT_W(5), .MAX_ITER(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2), .data_in(data_in2),
        .lt(lt2), .gt(gt2), .eq(eq2), .in_ready(in_ready2), .ldA(ldA2), .ldB(ldB2),
        .sel_in(sel_in2), .sel1(sel1_2), .sel2(sel2_2), .busy(busy2), .done(done2), .err(err2),
        .iters(iters2)
    );

    // Datapath models
    always_comb begin
        sub  = (sel1 ? b_reg : a_reg) - (sel2 ? b_reg : a_reg);
        bus  = sel_in ? sub : data_in;
        lt   = (a_reg < b_reg);
        gt   = (a_reg > b_reg);
        eq   = (a_reg == b_reg);
        sub2 = (sel1_2 ? b_reg2 : a_reg2) - (sel2_2 ? b_reg2 : a_reg2);
        bus2 = sel_in2 ? sub2 : data_in2;
        lt2  = (a_reg2 < b_reg2);
        gt2  = (a_reg2 > b_reg2);
        eq2  = (a_reg2 == b_reg2);
    end

    always_ff @(posedge clk) begin
        if (ldA)  a_reg  <= bus;
        if (ldB)  b_reg  <= bus;
        if (ldA2) a_reg2 <= bus2;
        if (ldB2) b_reg2 <= bus2;
    end

    always @(negedge clk) begin
        if (ldA) lda_cnt++;
        if (ldB) ldb_cnt++;
        if (ldA && ldB) both_cnt++;
        if (!ldA && !ldB && (sel_in || sel1 || sel2)) sel_viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input logic [3:0] a, input logic [3:0] b, output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        data_in = a;
        tick();
        data_in = b;
        tick();
        in_valid = 1'b0;
        data_in = 4'd0;
        cyc = 0;
        while (!(done || err) && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
        n_checks++; if (iters !== 5'd0) begin n_fail++; $display("FAIL reset_iters: got %0d want 0", iters); end
        n_checks++; if ({in_ready, ldA, ldB, sel_in, sel1, sel2} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {in_ready, ldA, ldB, sel_in, sel1, sel2}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int cyc, la, lb;
        la = lda_cnt; lb = ldb_cnt;
        run1(4'd12, 4'd8, cyc);
        n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL t1_done_err: got %b%b want 10", done, err); end
        n_checks++; if (iters !== 5'd2) begin n_fail++; $display("FAIL t1_iters: got %0d want 2", iters); end
        n_checks++; if (a_reg !== 4'd4) begin n_fail++; $display("FAIL t1_result: got %0d want 4", a_reg); end
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL t1_latency: got %0d want 3", cyc); end
        n_checks++; if (lda_cnt - la !== 2 || ldb_cnt - lb !== 2) begin n_fail++; $display("FAIL t1_loads: got %0d/%0d want 2/2", lda_cnt - la, ldb_cnt - lb); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_finish_busy: got %b want 1", busy); end
        tick();
        n_checks++; if (busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL t1_idle_sticky: got busy=%b done=%b want 0 1", busy, done); end
    endtask

    task automatic test_long_run();
        int cyc, la, lb;
        la = lda_cnt; lb = ldb_cnt;
        run1(4'd15, 4'd1, cyc);
        n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL t2_done_err: got %b%b want 10", done, err); end
        n_checks++; if (iters !== 5'd14) begin n_fail++; $display("FAIL t2_iters: got %0d want 14", iters); end
        n_checks++; if (a_reg !== 4'd1) begin n_fail++; $display("FAIL t2_result: got %0d want 1", a_reg); end
        n_checks++; if (lda_cnt - la !== 15 || ldb_cnt - lb !== 1) begin n_fail++; $display("FAIL t2_loads: got %0d/%0d want 15/1", lda_cnt - la, ldb_cnt - lb); end
        n_checks++; if (cyc !== 15) begin n_fail++; $display("FAIL t2_latency: got %0d want 15", cyc); end
        tick();
    endtask

    task automatic test_equal();
        int cyc, la, lb;
        la = lda_cnt; lb = ldb_cnt;
        run1(4'd7, 4'd7, cyc);
        n_checks++; if (done !== 1'b1 || iters !== 5'd0) begin n_fail++; $display("FAIL t3_done_iters: got done=%b iters=%0d want 1 0", done, iters); end
        n_checks++; if (lda_cnt - la !== 1 || ldb_cnt - lb !== 1) begin n_fail++; $display("FAIL t3_loads: got %0d/%0d want 1/1", lda_cnt - la, ldb_cnt - lb); end
        n_checks++; if (cyc !== 1 || a_reg !== 4'd7) begin n_fail++; $display("FAIL t3_latency_result: got cyc=%0d a=%0d want 1 7", cyc, a_reg); end
        tick();
    endtask

    task automatic test_zero_operand();
        int cyc;
        run1(4'd0, 4'd5, cyc);
        n_checks++; if (err !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL t4a_err_done: got %b%b want 10", err, done); end
        n_checks++; if (cyc !== 0 || busy !== 1'b1 || iters !== 5'd0) begin n_fail++; $display("FAIL t4a_finish: got cyc=%0d busy=%b iters=%0d want 0 1 0", cyc, busy, iters); end
        tick();
        n_checks++; if (busy !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL t4a_idle: got busy=%b err=%b want 0 1", busy, err); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (err !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL t4_clear: got err=%b in_ready=%b want 0 1", err, in_ready); end
        in_valid = 1'b1; data_in = 4'd5;
        tick();
        data_in = 4'd0;
        tick();
        in_valid = 1'b0;
        n_checks++; if (err !== 1'b1 || done !== 1'b0 || iters !== 5'd0) begin n_fail++; $display("FAIL t4b_err: got err=%b done=%b iters=%0d want 1 0 0", err, done, iters); end
        tick();
    endtask

    task automatic test_timeout();
        int cyc;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        in_valid2 = 1'b1; data_in2 = 4'd15;
        tick();
        data_in2 = 4'd1;
        tick();
        in_valid2 = 1'b0;
        cyc = 0;
        while (!(done2 || err2) && cyc < 40) begin
            tick();
            cyc++;
        end
        n_checks++; if (err2 !== 1'b1 || done2 !== 1'b0) begin n_fail++; $display("FAIL t5_err_done: got %b%b want 10", err2, done2); end
        n_checks++; if (iters2 !== 5'd4 || cyc !== 5) begin n_fail++; $display("FAIL t5_iters: got iters=%0d cyc=%0d want 4 5", iters2, cyc); end
        n_checks++; if (a_reg2 !== 4'd11) begin n_fail++; $display("FAIL t5_areg: got %0d want 11", a_reg2); end
        tick();
    endtask

    task automatic test_stall_restart_reset();
        int cyc, lb;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; data_in = 4'd12;
        tick();
        in_valid = 1'b0; data_in = 4'd3;
        lb = ldb_cnt;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (in_ready !== 1'b1 || busy !== 1'b1 || ldB !== 1'b0) begin n_fail++; $display("FAIL t6_stall%0d: got rdy=%b busy=%b ldB=%b want 1 1 0", i, in_ready, busy, ldB); end
        end
        n_checks++; if (ldb_cnt - lb !== 0) begin n_fail++; $display("FAIL t6_stall_loads: got %0d want 0", ldb_cnt - lb); end
        in_valid = 1'b1; data_in = 4'd8;
        tick();
        in_valid = 1'b0; data_in = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || iters !== 5'd1) begin n_fail++; $display("FAIL t6_start_ignored: got rdy=%b busy=%b iters=%0d want 0 1 1", in_ready, busy, iters); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || iters !== 5'd0) begin n_fail++; $display("FAIL t6_async_reset: got busy=%b done=%b err=%b iters=%0d want 0 0 0 0", busy, done, err, iters); end
        n_checks++; if ({ldA, ldB, sel_in, sel1, sel2} !== 5'b0) begin n_fail++; $display("FAIL t6_reset_ctrl: got %b want 00000", {ldA, ldB, sel_in, sel1, sel2}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run1(4'd12, 4'd8, cyc);
        n_checks++; if (done !== 1'b1 || iters !== 5'd2 || a_reg !== 4'd4) begin n_fail++; $display("FAIL t6_rerun: got done=%b iters=%0d a=%0d want 1 2 4", done, iters, a_reg); end
        tick();
    endtask

    task automatic test_invariants();
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL both_loads: got %0d cycles want 0", both_cnt); end
        n_checks++; if (sel_viol !== 0) begin n_fail++; $display("FAIL idle_sel: got %0d cycles want 0", sel_viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_run();
        test_equal();
        test_zero_operand();
        test_timeout();
        test_stall_restart_reset();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
